// File: rtl/chip8_sound_pkg.sv
// Shared types and default parameters for the CHIP-8 sound timer / beep sequencer.
package chip8_sound_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int          DEFAULT_TICK_DIV  = 188160;
    localparam int          DEFAULT_TONE_HALF = 50;
    localparam logic [15:0] DEFAULT_AMPLITUDE = 16'h2000;
    localparam logic [15:0] DEFAULT_RAMP_STEP = 16'h0100;

    // Two's-complement negation of an unsigned 16-bit magnitude.
    function automatic logic [15:0] negate16(input logic [15:0] m);
        return ~m + 16'd1;
    endfunction

endpackage

// File: rtl/chip8_tick_divider.sv
// Free-running divider producing a one-cycle tick every DIV enabled clocks; frozen while en is low.
module chip8_tick_divider #(
    parameter int DIV = 188160
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/chip8_sound_sequencer.sv
// CHIP-8 sound timer with square-tone beep sequencing (IDLE/PLAY/RELEASE) toward the audio codec.
// Optional macro CHIP8_SOUND_ENVELOPE_EN adds a linear attack/release envelope.
module chip8_sound_sequencer
    import chip8_sound_pkg::*;
#(
    parameter int          TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int          TONE_HALF = DEFAULT_TONE_HALF,
    parameter logic [15:0] AMPLITUDE = DEFAULT_AMPLITUDE,
    parameter logic [15:0] RAMP_STEP = DEFAULT_RAMP_STEP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               st_wr,
    input  logic [7:0]         st_wdata,
    input  logic               halt,
    input  logic               sample_req,
    output logic [7:0]         st_value,
    output logic signed [15:0] audio_output,
    output logic               is_on
);
    localparam int             SCW       = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
    localparam logic [SCW-1:0] SCNT_LAST = SCW'(TONE_HALF - 1);

    state_t             state_q, state_d;
    logic [7:0]         st_q, st_d;
    logic [SCW-1:0]     scnt_q, scnt_d;
    logic               pol_q, pol_d;
    logic signed [15:0] audio_q, audio_d;
    logic [15:0]        mag;
    logic               rel_done;
    logic               tick;
`ifdef CHIP8_SOUND_ENVELOPE_EN
    logic [15:0]        env_q, env_d;
`endif

    function automatic logic [15:0] sat_up(input logic [15:0] e);
        logic [16:0] s;
        s = {1'b0, e} + {1'b0, RAMP_STEP};
        return (s > {1'b0, AMPLITUDE}) ? AMPLITUDE : s[15:0];
    endfunction

    function automatic logic [15:0] sat_down(input logic [15:0] e);
        return (e > RAMP_STEP) ? e - RAMP_STEP : 16'd0;
    endfunction

    chip8_tick_divider #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (!halt),
        .tick  (tick)
    );

    // st_wr has priority over a coincident tick; the timer never wraps below zero.
    always_comb begin
        st_d = st_q;
        if (st_wr) begin
            st_d = st_wdata;
        end else if (tick && (st_q != 8'd0)) begin
            st_d = st_q - 8'd1;
        end
    end

    // Magnitude of the next sample and the condition that ends the release tail.
    always_comb begin
`ifdef CHIP8_SOUND_ENVELOPE_EN
        mag      = (state_q == PLAY) ? sat_up(env_q) : sat_down(env_q);
        rel_done = (mag == 16'd0);
`else
        mag      = AMPLITUDE;
        rel_done = !pol_q && (scnt_q == SCNT_LAST);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (st_q != 8'd0) state_d = PLAY;
            PLAY:    if (st_q == 8'd0) state_d = RELEASE;
            RELEASE: begin
                if (st_q != 8'd0) begin
                    state_d = PLAY;
                end else if (sample_req && rel_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_on   = (state_q != IDLE);
        audio_d = audio_q;
        scnt_d  = scnt_q;
        pol_d   = pol_q;
`ifdef CHIP8_SOUND_ENVELOPE_EN
        env_d   = env_q;
`endif
        if (state_q == IDLE) begin
            audio_d = '0;
            scnt_d  = '0;
            pol_d   = 1'b1;
`ifdef CHIP8_SOUND_ENVELOPE_EN
            env_d   = '0;
`endif
        end else if (sample_req) begin
            audio_d = pol_q ? $signed(mag) : $signed(negate16(mag));
`ifdef CHIP8_SOUND_ENVELOPE_EN
            env_d   = mag;
`endif
            if (scnt_q == SCNT_LAST) begin
                scnt_d = '0;
                pol_d  = !pol_q;
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
            // Final release sample lands on zero so the tone ends without a DC step.
            if ((state_q == RELEASE) && rel_done && (st_q == 8'd0)) begin
                audio_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= '0;
            scnt_q  <= '0;
            pol_q   <= 1'b1;
            audio_q <= '0;
`ifdef CHIP8_SOUND_ENVELOPE_EN
            env_q   <= '0;
`endif
        end else begin
            st_q    <= st_d;
            scnt_q  <= scnt_d;
            pol_q   <= pol_d;
            audio_q <= audio_d;
`ifdef CHIP8_SOUND_ENVELOPE_EN
            env_q   <= env_d;
`endif
        end
    end

    assign st_value     = st_q;
    assign audio_output = audio_q;

endmodule

// File: tb/tb_chip8_sound_sequencer.sv
// Directed bench for chip8_sound_sequencer with a shortened tick divider (TICK_DIV=10).
module tb_chip8_sound_sequencer;

`ifdef CHIP8_SOUND_ENVELOPE_EN
    localparam logic [15:0] TB_RAMP = 16'h0800;
`else
    localparam logic [15:0] TB_RAMP = 16'h0100;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               st_wr = 1'b0;
    logic [7:0]         st_wdata = 8'd0;
    logic               halt = 1'b0;
    logic               sample_req = 1'b0;
    logic [7:0]         st_value;
    logic signed [15:0] audio_output;
    logic               is_on;

    int errors = 0;
    int checks = 0;

    chip8_sound_sequencer #(
        .TICK_DIV  (10),
        .TONE_HALF (50),
        .AMPLITUDE (16'h2000),
        .RAMP_STEP (TB_RAMP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .st_wr        (st_wr),
        .st_wdata     (st_wdata),
        .halt         (halt),
        .sample_req   (sample_req),
        .st_value     (st_value),
        .audio_output (audio_output),
        .is_on        (is_on)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        st_wr      = 1'b0;
        sample_req = 1'b0;
        halt       = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_st(input logic [7:0] v);
        st_wdata = v;
        st_wr    = 1'b1;
        step();
        st_wr    = 1'b0;
    endtask

    task automatic send_sample();
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) begin
            send_sample();
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (st_value !== 8'd0) begin errors++; $display("FAIL reset_st st_value=%0d want 0", st_value); end
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL reset_audio audio=%h want 0000", audio_output); end
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL reset_is_on is_on=%b want 0", is_on); end
        reset = 1'b0;
        step();
        step();
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL reset_idle is_on=%b want 0", is_on); end
    endtask

    // ST=3 counts down one per tick; is_on holds until the release period boundary.
    task automatic test_countdown();
        logic [7:0] prev;
        logic [7:0] want;
        int n;
        halt = 1'b0;
        load_st(8'd3);
        checks++; if (st_value !== 8'd3) begin errors++; $display("FAIL cd_load st_value=%0d want 3", st_value); end
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL cd_is_on_pre is_on=%b want 0", is_on); end
        step();
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL cd_is_on_play is_on=%b want 1", is_on); end
        prev = st_value;
        for (int k = 0; k < 3; k++) begin
            want = 8'(2 - k);
            n = 0;
            while ((st_value == prev) && (n < 12)) begin
                step();
                n++;
            end
            checks++;
            if (st_value !== want) begin
                errors++;
                $display("FAIL cd_tick%0d st_value=%0d want %0d after %0d cycles", k, st_value, want, n);
            end
            if (k > 0) begin
                checks++; if (n != 10) begin errors++; $display("FAIL cd_period%0d cycles=%0d want 10", k, n); end
            end
            prev = st_value;
        end
        repeat (40) step();
        checks++; if (st_value !== 8'd0) begin errors++; $display("FAIL cd_no_wrap st_value=%0d want 0", st_value); end
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL cd_release_hold is_on=%b want 1", is_on); end
        // 50 positive + 49 negative samples; the 100th sample is the boundary.
        send_n(99);
        checks++; if (audio_output !== 16'hE000) begin errors++; $display("FAIL cd_tail audio=%h want e000", audio_output); end
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL cd_tail_on is_on=%b want 1", is_on); end
        send_sample();
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL cd_end_audio audio=%h want 0000", audio_output); end
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL cd_end_on is_on=%b want 0", is_on); end
    endtask

    // One sample every 4 clocks: 50 x 2000 then 50 x E000, each 1 clk after its request.
    task automatic test_tone();
        logic [15:0] exp_v;
        halt = 1'b1;
        load_st(8'd200);
        step();
        for (int i = 0; i < 100; i++) begin
            exp_v = (i < 50) ? 16'h2000 : 16'hE000;
            sample_req = 1'b1;
            if (i == 0) begin
                checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL tone_latency audio=%h want 0000", audio_output); end
            end
            step();
            sample_req = 1'b0;
            checks++; if (audio_output !== exp_v) begin errors++; $display("FAIL tone_s%0d audio=%h want %h", i, audio_output, exp_v); end
            repeat (3) step();
            checks++; if (audio_output !== exp_v) begin errors++; $display("FAIL tone_hold%0d audio=%h want %h", i, audio_output, exp_v); end
        end
    endtask

    // Asynchronous reset while playing clears everything without waiting for a clock edge.
    task automatic test_reset_mid_play();
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL rmp_pre is_on=%b want 1", is_on); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (st_value !== 8'd0) begin errors++; $display("FAIL rmp_st st_value=%0d want 0", st_value); end
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL rmp_audio audio=%h want 0000", audio_output); end
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL rmp_is_on is_on=%b want 0", is_on); end
        step();
        reset = 1'b0;
        halt  = 1'b0;
        step();
        step();
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL rmp_no_tail is_on=%b want 0", is_on); end
    endtask

    // st_wr coinciding with a tick wins; halt freezes both the divider and ST.
    task automatic test_load_priority_halt();
        int n;
        do_reset();
        load_st(8'd3);
        n = 0;
        while ((st_value != 8'd2) && (n < 12)) begin
            step();
            n++;
        end
        checks++; if (st_value !== 8'd2) begin errors++; $display("FAIL lp_sync st_value=%0d want 2", st_value); end
        repeat (9) step();
        st_wdata = 8'd5;
        st_wr    = 1'b1;
        step();
        st_wr    = 1'b0;
        checks++; if (st_value !== 8'd5) begin errors++; $display("FAIL lp_priority st_value=%0d want 5", st_value); end
        repeat (9) step();
        checks++; if (st_value !== 8'd5) begin errors++; $display("FAIL lp_pre_tick st_value=%0d want 5", st_value); end
        step();
        checks++; if (st_value !== 8'd4) begin errors++; $display("FAIL lp_tick st_value=%0d want 4", st_value); end
        halt = 1'b1;
        repeat (35) step();
        checks++; if (st_value !== 8'd4) begin errors++; $display("FAIL lp_halt st_value=%0d want 4", st_value); end
        halt = 1'b0;
        repeat (9) step();
        checks++; if (st_value !== 8'd4) begin errors++; $display("FAIL lp_resume_pre st_value=%0d want 4", st_value); end
        step();
        checks++; if (st_value !== 8'd3) begin errors++; $display("FAIL lp_resume st_value=%0d want 3", st_value); end
    endtask

    // ST cleared at sample 20 of the + half; tail runs to the period boundary. Re-arm keeps phase.
    task automatic test_release();
        do_reset();
        halt = 1'b1;
        load_st(8'd9);
        step();
        send_n(20);
        checks++; if (audio_output !== 16'h2000) begin errors++; $display("FAIL rel_s19 audio=%h want 2000", audio_output); end
        load_st(8'd0);
        step();
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL rel_on is_on=%b want 1", is_on); end
        send_n(30);
        checks++; if (audio_output !== 16'h2000) begin errors++; $display("FAIL rel_s49 audio=%h want 2000", audio_output); end
        send_n(49);
        checks++; if (audio_output !== 16'hE000) begin errors++; $display("FAIL rel_s98 audio=%h want e000", audio_output); end
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL rel_s98_on is_on=%b want 1", is_on); end
        send_sample();
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL rel_exit audio=%h want 0000", audio_output); end
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL rel_exit_on is_on=%b want 0", is_on); end
        step();
        send_sample();
        checks++; if (audio_output !== 16'sd0) begin errors++; $display("FAIL rel_idle_req audio=%h want 0000", audio_output); end

        load_st(8'd9);
        step();
        send_n(10);
        load_st(8'd0);
        step();
        send_n(45);
        checks++; if (audio_output !== 16'hE000) begin errors++; $display("FAIL rel2_s54 audio=%h want e000", audio_output); end
        load_st(8'd4);
        step();
        checks++; if (st_value !== 8'd4) begin errors++; $display("FAIL rel2_st st_value=%0d want 4", st_value); end
        checks++; if (is_on !== 1'b1) begin errors++; $display("FAIL rel2_on is_on=%b want 1", is_on); end
        send_n(1);
        checks++; if (audio_output !== 16'hE000) begin errors++; $display("FAIL rel2_phase audio=%h want e000", audio_output); end
        send_n(44);
        checks++; if (audio_output !== 16'hE000) begin errors++; $display("FAIL rel2_s99 audio=%h want e000", audio_output); end
        send_n(1);
        checks++; if (audio_output !== 16'h2000) begin errors++; $display("FAIL rel2_s100 audio=%h want 2000", audio_output); end
    endtask

`ifdef CHIP8_SOUND_ENVELOPE_EN
    task automatic test_envelope();
        logic [15:0] atk [5];
        logic [15:0] rel [4];
        atk = '{16'h0800, 16'h1000, 16'h1800, 16'h2000, 16'h2000};
        rel = '{16'h1800, 16'h1000, 16'h0800, 16'h0000};
        do_reset();
        halt = 1'b1;
        load_st(8'd9);
        step();
        for (int i = 0; i < 5; i++) begin
            send_n(1);
            checks++; if (audio_output !== atk[i]) begin errors++; $display("FAIL env_atk%0d audio=%h want %h", i, audio_output, atk[i]); end
        end
        load_st(8'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            send_n(1);
            checks++; if (audio_output !== rel[i]) begin errors++; $display("FAIL env_rel%0d audio=%h want %h", i, audio_output, rel[i]); end
        end
        checks++; if (is_on !== 1'b0) begin errors++; $display("FAIL env_idle is_on=%b want 0", is_on); end
    endtask
`endif

    initial begin
        test_reset();
        test_countdown();
        test_tone();
        test_reset_mid_play();
        test_load_priority_halt();
        test_release();
`ifdef CHIP8_SOUND_ENVELOPE_EN
        test_envelope();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
